// File: rtl/systolic_result_collector.sv
// Deskews the five skewed systolic-array column outputs into aligned result vectors,
// buffers them in a small FIFO and hands them downstream over valid/ready.
module systolic_result_collector #(
    parameter int DW         = 16,
    parameter int FIRST_LAT  = 5,
    parameter int VEC_COUNT  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            start,
    input  logic [DW-1:0]   sa_out1,
    input  logic [DW-1:0]   sa_out2,
    input  logic [DW-1:0]   sa_out3,
    input  logic [DW-1:0]   sa_out4,
    input  logic [DW-1:0]   sa_out5,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [5*DW-1:0] res_data,
    output logic            res_last,
    output logic            busy,
    output logic            overflow
);

    // state    | meaning
    // IDLE     | waiting for start
    // WAIT     | counting down to the first aligned vector
    // CAPTURE  | pushing one aligned vector per cycle
    // DRAIN    | job captured, waiting for the FIFO to empty
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

    localparam int CW = $clog2(FIRST_LAT + VEC_COUNT + 4);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DW-1:0]   dl1_q [4];
    logic [DW-1:0]   dl1_d [4];
    logic [DW-1:0]   dl2_q [3];
    logic [DW-1:0]   dl2_d [3];
    logic [DW-1:0]   dl3_q [2];
    logic [DW-1:0]   dl3_d [2];
    logic [DW-1:0]   dl4_q, dl4_d;

    logic [5*DW-1:0] mem_q  [FIFO_DEPTH];
    logic [5*DW-1:0] mem_d  [FIFO_DEPTH];
    logic            last_q [FIFO_DEPTH];
    logic            last_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [5*DW-1:0] aligned;
    logic            push, push_ok, pop, full;

    // Delay lines shift every cycle, independent of the FSM.
    always_comb begin
        dl1_d[0] = sa_out1;
        for (int i = 1; i < 4; i++) dl1_d[i] = dl1_q[i-1];
        dl2_d[0] = sa_out2;
        for (int i = 1; i < 3; i++) dl2_d[i] = dl2_q[i-1];
        dl3_d[0] = sa_out3;
        dl3_d[1] = dl3_q[0];
        dl4_d    = sa_out4;
    end

    assign aligned = {sa_out5, dl4_q, dl3_q[1], dl2_q[2], dl1_q[3]};

    always_comb begin
        full    = (count_q == (AW+1)'(FIFO_DEPTH));
        pop     = (count_q != '0) && res_ready;
        push    = (state_q == S_CAPTURE);
        push_ok = push && (!full || pop);

        mem_d    = mem_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q]  = aligned;
            last_d[wr_ptr_q] = (cnt_q == '0);
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        ovf_d   = ovf_q | (push && !push_ok);
    end

    // Down-counter reloaded per phase; zero marks the last WAIT / last CAPTURE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(FIRST_LAT + 2);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                    cnt_d   = CW'(VEC_COUNT - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CAPTURE: begin
                if (cnt_q == '0) state_d = S_DRAIN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_DRAIN: begin
                if (count_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            for (int i = 0; i < 4; i++) dl1_q[i] <= '0;
            for (int i = 0; i < 3; i++) dl2_q[i] <= '0;
            for (int i = 0; i < 2; i++) dl3_q[i] <= '0;
            dl4_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dl1_q    <= dl1_d;
            dl2_q    <= dl2_d;
            dl3_q    <= dl3_d;
            dl4_q    <= dl4_d;
            mem_q    <= mem_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign res_valid = (count_q != '0);
    assign res_data  = res_valid ? mem_q[rd_ptr_q] : '0;
    assign res_last  = res_valid ? last_q[rd_ptr_q] : 1'b0;
    assign busy      = (state_q != S_IDLE) || res_valid;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench for systolic_result_collector: a queue-based job model predicts every output each cycle.
module tb_systolic_result_collector;

    localparam int DW    = 16;
    localparam int FL    = 5;
    localparam int VC    = 5;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            clear, start, res_ready;
    logic [DW-1:0]   sa1, sa2, sa3, sa4, sa5;
    logic            res_valid, res_last, busy, overflow;
    logic [5*DW-1:0] res_data;

    systolic_result_collector #(.DW(DW), .FIRST_LAT(FL), .VEC_COUNT(VC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .clear(clear), .start(start),
        .sa_out1(sa1), .sa_out2(sa2), .sa_out3(sa3), .sa_out4(sa4), .sa_out5(sa5),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5*DW-1:0] data;
        bit              last;
    } ent_t;

    ent_t          q[$];
    bit            job_flag, m_ovf, pat_mode;
    int            job_s = -1000;
    int            cyc;
    logic [DW-1:0] vec [VC][5];
    int            n_vec, n_err;

    // {res_valid, res_last, busy, overflow, res_data} the model expects this cycle
    function automatic logic [5*DW+3:0] exp_out();
        logic [5*DW-1:0] d = '0;
        bit l = 1'b0;
        bit v = (q.size() > 0);
        if (v) begin
            d = q[0].data;
            l = q[0].last;
        end
        return {v, l, job_flag | v, m_ovf, d};
    endfunction

    // Drives one cycle of inputs (from a negedge) and advances the model across the next posedge.
    task automatic step(input bit st, input bit rdy, input bit clr);
        logic [DW-1:0] lane [5];
        int v;
        ent_t e;
        bit pop;
        for (int k = 0; k < 5; k++) begin
            v = cyc - job_s - FL - k;
            lane[k] = (v >= 0 && v < VC) ? vec[v][k] : DW'($urandom);
        end
        sa1 = lane[0]; sa2 = lane[1]; sa3 = lane[2]; sa4 = lane[3]; sa5 = lane[4];
        start = st; res_ready = rdy; clear = clr;
        if (clr) begin
            q.delete();
            job_flag = 1'b0;
            m_ovf    = 1'b0;
            job_s    = -1000;
        end else begin
            pop = (q.size() > 0) && rdy;
            if (pop) void'(q.pop_front());
            if (job_flag && cyc >= job_s + FL + 4 && cyc <= job_s + FL + 3 + VC) begin
                v = cyc - job_s - FL - 4;
                for (int k = 0; k < 5; k++) e.data[k*DW +: DW] = vec[v][k];
                e.last = (v == VC - 1);
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1'b1;
            end
            if (job_flag) begin
                if (cyc >= job_s + FL + 4 + VC && q.size() == 0) job_flag = 1'b0;
            end else if (st) begin
                job_flag = 1'b1;
                job_s    = cyc;
                for (int vv = 0; vv < VC; vv++)
                    for (int k = 0; k < 5; k++)
                        vec[vv][k] = pat_mode ? {4'h0, 4'(k + 1), 4'h0, 4'(vv)} : DW'($urandom);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; res_ready = 1'b0;
        sa1 = '0; sa2 = '0; sa3 = '0; sa4 = '0; sa5 = '0;
        #1;
        n_vec++;
        if ({res_valid, res_last, busy, overflow, res_data} !== '0) begin
            n_err++;
            $display("FAIL reset got=%h exp=0", {res_valid, res_last, busy, overflow, res_data});
        end
        @(negedge clk);
        step(0, 1, 1);
        n_vec++;
        if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
            n_err++;
            $display("FAIL reset_hold got=%h exp=%h", {res_valid, res_last, busy, overflow, res_data}, exp_out());
        end
    endtask

    task automatic test_basic();
        pat_mode = 1'b1;
        step(0, 1, 1);
        for (int i = 0; i < 25; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL basic i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step(i == 0, 1, 0);
        end
        pat_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        step(0, 1, 1);
        for (int i = 0; i < 40; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL backpressure i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step(i == 0, i >= 20, 0);
        end
    endtask

    task automatic test_full_pop();
        step(0, 1, 1);
        for (int i = 0; i < 30; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL full_pop i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step(i == 0, i >= 13, 0);
        end
    endtask

    task automatic test_ignored_start();
        pat_mode = 1'b1;
        step(0, 1, 1);
        for (int i = 0; i < 25; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL ignored_start i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step(i == 0 || i == 7, 1, 0);
        end
        pat_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        step(0, 1, 1);
        for (int i = 0; i < 11; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL reset_mid_pre i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step(i == 0, 0, 0);
        end
        clear = 1'b1;
        #1;
        n_vec++;
        if ({res_valid, busy, overflow} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_async got=%b exp=000", {res_valid, busy, overflow});
        end
        @(negedge clk);
        step(0, 0, 1);
        for (int i = 0; i < 25; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL reset_mid_rerun i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step(i == 0, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        bit started2 = 1'b0;
        bit st;
        int pops = 0, lasts = 0;
        step(0, 1, 1);
        for (int i = 0; i < 45; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL back_to_back i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            if (res_valid) begin
                pops++;
                if (res_last) lasts++;
            end
            st = (i == 0) || (i > 0 && !job_flag && !started2);
            if (i > 0 && st) started2 = 1'b1;
            step(st, 1, 0);
        end
        n_vec++;
        if (pops != 10 || lasts != 2) begin
            n_err++;
            $display("FAIL back_to_back_count pops=%0d lasts=%0d exp pops=10 lasts=2", pops, lasts);
        end
    endtask

    task automatic test_random();
        step(0, 1, 1);
        for (int i = 0; i < 250; i++) begin
            n_vec++;
            if ({res_valid, res_last, busy, overflow, res_data} !== exp_out()) begin
                n_err++;
                $display("FAIL random i=%0d got=%h exp=%h", i, {res_valid, res_last, busy, overflow, res_data}, exp_out());
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, 0);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        job_flag = 1'b0; m_ovf = 1'b0; pat_mode = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pop();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
